// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer sharing one WIDTH-bit subtractor for SUB/SLT/MIN/DIV.
// Optional ALU_SEQ_STATS_EN adds a saturating completed-operation counter (op_count).
module alu_seq_ctrl #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] y,
   output logic               err
`ifdef ALU_SEQ_STATS_EN
   ,
   output logic [15:0]        op_count
`endif
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] OpSub = 2'b00;
   localparam logic [1:0] OpSlt = 2'b01;
   localparam logic [1:0] OpDiv = 2'b10;
   localparam logic [1:0] OpMin = 2'b11;

   typedef enum logic [1:0] {StIdle, StLoad, StIter, StDone} state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [1:0]           op_q, op_d;
   logic [WIDTH-1:0]     r_q, r_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   y_q, y_d;
   logic                 err_q, err_d;

   logic [WIDTH-1:0]     r_shift;
   logic [WIDTH-1:0]     sub_x;
   logic [WIDTH:0]       diff;
   logic                 bout;
   logic [WIDTH-1:0]     r_nxt;
   logic [WIDTH-1:0]     q_nxt;

   // Shared subtractor: dividend-shifted remainder in ITER, operand A otherwise
   assign r_shift = {r_q[WIDTH-2:0], a_q[cnt_q]};
   assign sub_x   = (state_q == StIter) ? r_shift : a_q;
   assign diff    = {1'b0, sub_x} - {1'b0, b_q};
   assign bout    = diff[WIDTH];

   // Restoring step: keep the shifted remainder when the subtraction borrows
   assign r_nxt = bout ? r_shift : diff[WIDTH-1:0];
   assign q_nxt = {q_q[WIDTH-2:0], ~bout};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      r_d     = r_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               state_d = StLoad;
            end
         end
         StLoad: begin
            state_d = StDone;
            err_d   = 1'b0;
            unique case (op_q)
               OpSub: begin
                  y_d                = '0;
                  y_d[WIDTH-1:0]     = diff[WIDTH-1:0];
                  y_d[2*WIDTH-1]     = bout;
               end
               OpSlt: begin
                  y_d                = '0;
                  y_d[2*WIDTH-1]     = bout;
               end
               OpMin: begin
                  y_d = {{WIDTH{1'b0}}, (bout ? a_q : b_q)};
               end
               OpDiv: begin
                  if (b_q == '0) begin
                     y_d   = {a_q, {WIDTH{1'b1}}};
                     err_d = 1'b1;
                  end else begin
                     // err and y stay untouched until the division completes
                     err_d   = err_q;
                     r_d     = '0;
                     q_d     = '0;
                     cnt_d   = CW'(WIDTH - 1);
                     state_d = StIter;
                  end
               end
               default: ;
            endcase
         end
         StIter: begin
            r_d   = r_nxt;
            q_d   = q_nxt;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               y_d     = {r_nxt, q_nxt};
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         r_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         y_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         r_q     <= r_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         err_q   <= err_d;
      end
   end

   assign ready = (state_q == StIdle);
   assign busy  = (state_q == StLoad) || (state_q == StIter);
   assign done  = (state_q == StDone);
   assign y     = y_q;
   assign err   = err_q;

`ifdef ALU_SEQ_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_count <= '0;
      end else if (done && (op_count != 16'hFFFF)) begin
         op_count <= op_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed cases plus randomized ops against
// an arithmetic reference model.
module tb_alu_seq_ctrl;

   localparam int W = 4;

   logic           clk   = 1'b0;
   logic           reset = 1'b0;
   logic           start = 1'b0;
   logic [1:0]     op    = 2'b00;
   logic [W-1:0]   a     = '0;
   logic [W-1:0]   b     = '0;
   logic           ready;
   logic           busy;
   logic           done;
   logic           err;
   logic [2*W-1:0] y;
`ifdef ALU_SEQ_STATS_EN
   logic [15:0]    op_count;
`endif

   int checks   = 0;
   int failures = 0;
   int ops_seen = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .y       (y),
      .err     (err)
`ifdef ALU_SEQ_STATS_EN
      ,
      .op_count(op_count)
`endif
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns {err, y} from plain arithmetic on the operands
   function automatic logic [8:0] model(input logic [1:0] o, input int x, input int z);
      int yv;
      bit e;
      e = 1'b0;
      case (o)
         2'd0: yv = ((x < z) ? 128 : 0) + ((x - z) & 15);
         2'd1: yv = (x < z) ? 128 : 0;
         2'd2: begin
            if (z == 0) begin
               yv = x * 16 + 15;
               e  = 1'b1;
            end else begin
               yv = (x % z) * 16 + (x / z);
            end
         end
         default: yv = (x < z) ? x : z;
      endcase
      return {e, yv[7:0]};
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [3:0] x, input logic [3:0] z,
                         input bit poke, input string tag);
      logic [8:0] exp;
      int n;
      int nbusy;
      int lat;
      exp = model(o, int'(x), int'(z));
      lat = (o == 2'd2 && z != 0) ? 5 : 1;
      @(negedge clk);
      check({tag, ":ready"}, 16'(ready), 16'd1);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = z;
      @(negedge clk);
      start = 1'b0;
      n     = 0;
      nbusy = 0;
      while (!done && n < 40) begin
         if (busy) nbusy++;
         if (poke && n == 2) begin
            start = 1'b1;
            op    = ~o;
            a     = ~x;
            b     = ~z;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check({tag, ":latency"}, 16'(n), 16'(lat));
      check({tag, ":busy_cycles"}, 16'(nbusy), 16'(lat));
      check({tag, ":y"}, 16'(y), 16'(exp[7:0]));
      check({tag, ":err"}, 16'(err), 16'(exp[8]));
      @(negedge clk);
      check({tag, ":done_width"}, 16'(done), 16'd0);
      check({tag, ":y_hold"}, 16'(y), 16'(exp[7:0]));
      ops_seen++;
   endtask

   initial begin
      int nd;
      logic [1:0] ro;
      logic [3:0] rx;
      logic [3:0] rz;

      // Asynchronous reset with no clock edge
      #1 reset = 1'b1;
      #1;
      check("rst:y", 16'(y), 16'h00);
      check("rst:done", 16'(done), 16'd0);
      check("rst:err", 16'(err), 16'd0);
      check("rst:ready", 16'(ready), 16'd1);
      check("rst:busy", 16'(busy), 16'd0);
      #10 reset = 1'b0;

      run_op(2'd1, 4'd3, 4'd9, 1'b0, "slt_lt");
      check("slt_lt:const", 16'(y), 16'h80);
      run_op(2'd1, 4'd9, 4'd3, 1'b0, "slt_gt");
      run_op(2'd1, 4'd5, 4'd5, 1'b0, "slt_eq");
      run_op(2'd0, 4'd2, 4'd5, 1'b0, "sub_neg");
      check("sub_neg:const", 16'(y), 16'h8D);
      run_op(2'd0, 4'd5, 4'd2, 1'b0, "sub_pos");
      run_op(2'd3, 4'd9, 4'd3, 1'b0, "min_b");
      run_op(2'd3, 4'd0, 4'd15, 1'b0, "min_a");
      run_op(2'd2, 4'd13, 4'd4, 1'b0, "div_13_4");
      check("div_13_4:const", 16'(y), 16'h13);
      run_op(2'd2, 4'd15, 4'd1, 1'b0, "div_15_1");
      run_op(2'd2, 4'd7, 4'd0, 1'b0, "div_zero");
      check("div_zero:const", 16'(y), 16'h7F);
      run_op(2'd0, 4'd1, 4'd1, 1'b0, "sub_after_dz");
      run_op(2'd2, 4'd13, 4'd4, 1'b1, "div_poke");

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         rx = 4'($urandom_range(0, 15));
         rz = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         run_op(ro, rx, rz, i[0], "rnd");
      end

`ifdef ALU_SEQ_STATS_EN
      check("stats:count", op_count, 16'(ops_seen));
`endif

      // Reset during the third division iteration
      run_op(2'd0, 4'd2, 4'd5, 1'b0, "pre_abort");
      @(negedge clk);
      start = 1'b1;
      op    = 2'd2;
      a     = 4'd13;
      b     = 4'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort:busy_before", 16'(busy), 16'd1);
      #2 reset = 1'b1;
      #1;
      check("abort:y", 16'(y), 16'h00);
      check("abort:ready", 16'(ready), 16'd1);
      check("abort:busy", 16'(busy), 16'd0);
      check("abort:done", 16'(done), 16'd0);
      #1 reset = 1'b0;
      ops_seen = 0;
      nd = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("abort:no_done", 16'(nd), 16'd0);
      check("abort:y_stays", 16'(y), 16'h00);
`ifdef ALU_SEQ_STATS_EN
      check("stats:cleared", op_count, 16'd0);
      run_op(2'd0, 4'd3, 4'd1, 1'b0, "st1");
      run_op(2'd2, 4'd9, 4'd0, 1'b0, "st2");
      run_op(2'd2, 4'd9, 4'd2, 1'b0, "st3");
      check("stats:three", op_count, 16'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
